// File: rtl/rc4_key_search_core.sv
// rtl/rc4_key_search_core.sv - single-engine RC4 brute-force key search over one shared S RAM
//
// Purpose: for every key in [key_first_i, key_last_i] run S init, the key schedule and a PRGA
// decrypt of the ciphertext ROM, writing plaintext to the decrypt RAM. With CHECK_ASCII set, a
// key is dropped on the first byte outside 'a'..'z' / space; otherwise the first key is accepted.
//
// Ports:
//   clock_i, reset_i              clock, asynchronous active-high reset
//   start_i                       1-cycle start pulse, samples key_first_i / key_last_i when idle
//   key_first_i, key_last_i       inclusive key range
//   busy_o, done_o, found_o       search in progress / 1-cycle end pulse / key accepted
//   key_out_o                     current key while busy, accepted or last-tried key after done
//   s_address_o, s_data_o,
//   s_wren_o, s_q_i               S RAM port (2-cycle read latency)
//   rom_address_o, rom_q_i        ciphertext ROM port (2-cycle read latency)
//   d_address_o, d_data_o,
//   d_wren_o                      decrypt RAM write port
module rc4_key_search_core #(
  parameter int KEY_BYTES      = 3,
  parameter int MESSAGE_LENGTH = 32,
  parameter bit CHECK_ASCII    = 1'b1,
  localparam int KW            = 8 * KEY_BYTES
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic [KW-1:0] key_first_i,
  input  logic [KW-1:0] key_last_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          found_o,
  output logic [KW-1:0] key_out_o,
  output logic [7:0]    s_address_o,
  output logic [7:0]    s_data_o,
  output logic          s_wren_o,
  input  logic [7:0]    s_q_i,
  output logic [7:0]    rom_address_o,
  input  logic [7:0]    rom_q_i,
  output logic [7:0]    d_address_o,
  output logic [7:0]    d_data_o,
  output logic          d_wren_o
);

  localparam logic [7:0] KB_LAST = 8'(KEY_BYTES - 1);
  localparam logic [7:0] K_LAST  = 8'(MESSAGE_LENGTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_KSA, S_PRGA, S_NEXT, S_FOUND, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    step_q, step_d;   // sub-step inside one KSA (0..7) or PRGA (0..11) iteration
  logic [7:0]    i_q, i_d, j_q, j_d, k_q, k_d;
  logic [7:0]    si_q, si_d, sj_q, sj_d, p_q, p_d;
  logic [7:0]    kb_q, kb_d;       // i mod KEY_BYTES, tracked alongside i during KSA
  logic [KW-1:0] key_q, key_d, last_q, last_d;

  logic          busy_q, busy_d, done_q, done_d, found_q, found_d;
  logic [7:0]    s_address_q, s_address_d, s_data_q, s_data_d;
  logic          s_wren_q, s_wren_d, d_wren_q, d_wren_d;
  logic [7:0]    rom_address_q, rom_address_d, d_address_q, d_address_d, d_data_q, d_data_d;

  logic [7:0]    kbyte;
  logic          p_ok;

  // Key byte 0 is the most significant byte of the key.
  always_comb begin
    kbyte = 8'h00;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (kb_q == 8'(b)) kbyte = key_q[KW-1-8*b -: 8];
    end
  end

  assign p_ok = ((p_q >= 8'h61) && (p_q <= 8'h7A)) || (p_q == 8'h20);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      step_q        <= 4'd0;
      i_q           <= 8'd0;
      j_q           <= 8'd0;
      k_q           <= 8'd0;
      si_q          <= 8'd0;
      sj_q          <= 8'd0;
      p_q           <= 8'd0;
      kb_q          <= 8'd0;
      key_q         <= '0;
      last_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      s_address_q   <= 8'd0;
      s_data_q      <= 8'd0;
      s_wren_q      <= 1'b0;
      rom_address_q <= 8'd0;
      d_address_q   <= 8'd0;
      d_data_q      <= 8'd0;
      d_wren_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_q        <= step_d;
      i_q           <= i_d;
      j_q           <= j_d;
      k_q           <= k_d;
      si_q          <= si_d;
      sj_q          <= sj_d;
      p_q           <= p_d;
      kb_q          <= kb_d;
      key_q         <= key_d;
      last_q        <= last_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      found_q       <= found_d;
      s_address_q   <= s_address_d;
      s_data_q      <= s_data_d;
      s_wren_q      <= s_wren_d;
      rom_address_q <= rom_address_d;
      d_address_q   <= d_address_d;
      d_data_q      <= d_data_d;
      d_wren_q      <= d_wren_d;
    end
  end

  // Next state and datapath. Reads take ADDR / WAIT / LATCH steps; s_q_i is captured in LATCH.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    si_d    = si_q;
    sj_d    = sj_q;
    p_d     = p_q;
    kb_d    = kb_q;
    key_d   = key_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          key_d   = key_first_i;
          last_d  = key_last_i;
          i_d     = 8'd0;
          state_d = (key_first_i > key_last_i) ? S_DONE : S_INIT;
        end
      end
      S_INIT: begin
        i_d = i_q + 8'd1;
        if (i_q == 8'hFF) begin
          state_d = S_KSA;
          step_d  = 4'd0;
          j_d     = 8'd0;
          kb_d    = 8'd0;
        end
      end
      S_KSA: begin
        step_d = step_q + 4'd1;
        case (step_q)
          4'd2: begin
            si_d = s_q_i;
            j_d  = j_q + s_q_i + kbyte;
          end
          4'd5: sj_d = s_q_i;
          4'd7: begin
            step_d = 4'd0;
            i_d    = i_q + 8'd1;
            kb_d   = (kb_q == KB_LAST) ? 8'd0 : kb_q + 8'd1;
            if (i_q == 8'hFF) begin
              // PRGA starts with i=j=k=0 and pre-increments i, so enter with i=1.
              state_d = S_PRGA;
              i_d     = 8'd1;
              j_d     = 8'd0;
              k_d     = 8'd0;
            end
          end
          default: ;
        endcase
      end
      S_PRGA: begin
        step_d = step_q + 4'd1;
        case (step_q)
          4'd2: begin
            si_d = s_q_i;
            j_d  = j_q + s_q_i;
          end
          4'd5:  sj_d = s_q_i;
          4'd10: p_d  = s_q_i ^ rom_q_i;
          4'd11: begin
            step_d = 4'd0;
            if (CHECK_ASCII && !p_ok) begin
              state_d = S_NEXT;
            end else if (k_q == K_LAST) begin
              state_d = S_FOUND;
            end else begin
              i_d = i_q + 8'd1;
              k_d = k_q + 8'd1;
            end
          end
          default: ;
        endcase
      end
      S_NEXT: begin
        // Compare before incrementing so an all-ones key_last never wraps.
        if (key_q == last_q) begin
          state_d = S_DONE;
        end else begin
          key_d   = key_q + KW'(1);
          i_d     = 8'd0;
          state_d = S_INIT;
        end
      end
      S_FOUND, S_DONE: state_d = S_IDLE;
      default:         state_d = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the upcoming state so they line up with it.
  always_comb begin
    s_address_d   = s_address_q;
    s_data_d      = s_data_q;
    s_wren_d      = 1'b0;
    rom_address_d = rom_address_q;
    d_address_d   = d_address_q;
    d_data_d      = d_data_q;
    d_wren_d      = 1'b0;
    busy_d        = state_d inside {S_INIT, S_KSA, S_PRGA, S_NEXT};
    done_d        = state_d inside {S_FOUND, S_DONE};
    found_d       = found_q;
    if (state_d == S_FOUND)                found_d = 1'b1;
    else if (state_q == S_IDLE && start_i) found_d = 1'b0;
    case (state_d)
      S_INIT: begin
        s_address_d = i_d;
        s_data_d    = i_d;
        s_wren_d    = 1'b1;
      end
      S_KSA, S_PRGA: begin
        case (step_d)
          4'd0: s_address_d = i_d;
          4'd3: s_address_d = j_d;
          4'd6: begin
            s_address_d = i_d;
            s_data_d    = sj_d;
            s_wren_d    = 1'b1;
          end
          4'd7: begin
            s_address_d = j_d;
            s_data_d    = si_d;
            s_wren_d    = 1'b1;
          end
          4'd8: begin
            s_address_d   = si_d + sj_d;
            rom_address_d = k_d;
          end
          4'd11: begin
            d_address_d = k_d;
            d_data_d    = p_d;
            d_wren_d    = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign found_o       = found_q;
  assign key_out_o     = key_q;
  assign s_address_o   = s_address_q;
  assign s_data_o      = s_data_q;
  assign s_wren_o      = s_wren_q;
  assign rom_address_o = rom_address_q;
  assign d_address_o   = d_address_q;
  assign d_data_o      = d_data_q;
  assign d_wren_o      = d_wren_q;

endmodule

// File: tb/tb_rc4_key_search_core.sv
// tb/tb_rc4_key_search_core.sv - self-checking bench for rc4_key_search_core
module tb_rc4_key_search_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel, start;
  logic [23:0] kf, kl;
  int          total = 0;
  int          bad = 0;
  int          wren_seen = 0;

  logic        start0, busy0, done0, found0, s_wren0, d_wren0;
  logic [23:0] key0;
  logic [7:0]  s_addr0, s_data0, s_q0, rom_addr0, rom_q0, d_addr0, d_data0, s_ar0, rom_ar0;
  logic        start1, busy1, done1, found1, s_wren1, d_wren1;
  logic [23:0] key1;
  logic [7:0]  s_addr1, s_data1, s_q1, rom_addr1, rom_q1, d_addr1, d_data1, s_ar1, rom_ar1;

  logic [7:0]  s_mem0[256], rom0[256], d_mem0[256];
  logic [7:0]  s_mem1[256], rom1[256], d_mem1[256];
  logic [7:0]  ct_m[256], pt_m[256];

  assign start0 = start & ~sel;
  assign start1 = start & sel;

  rc4_key_search_core #(.KEY_BYTES(3), .MESSAGE_LENGTH(9), .CHECK_ASCII(1'b0)) u_dut0 (
    .clock_i(clk), .reset_i(rst), .start_i(start0), .key_first_i(kf), .key_last_i(kl),
    .busy_o(busy0), .done_o(done0), .found_o(found0), .key_out_o(key0),
    .s_address_o(s_addr0), .s_data_o(s_data0), .s_wren_o(s_wren0), .s_q_i(s_q0),
    .rom_address_o(rom_addr0), .rom_q_i(rom_q0),
    .d_address_o(d_addr0), .d_data_o(d_data0), .d_wren_o(d_wren0));

  rc4_key_search_core #(.KEY_BYTES(3), .MESSAGE_LENGTH(32), .CHECK_ASCII(1'b1)) u_dut1 (
    .clock_i(clk), .reset_i(rst), .start_i(start1), .key_first_i(kf), .key_last_i(kl),
    .busy_o(busy1), .done_o(done1), .found_o(found1), .key_out_o(key1),
    .s_address_o(s_addr1), .s_data_o(s_data1), .s_wren_o(s_wren1), .s_q_i(s_q1),
    .rom_address_o(rom_addr1), .rom_q_i(rom_q1),
    .d_address_o(d_addr1), .d_data_o(d_data1), .d_wren_o(d_wren1));

  // Memories: registered address then registered data -> 2-cycle read latency.
  always @(posedge clk) begin
    if (s_wren0) s_mem0[s_addr0] <= s_data0;
    s_ar0   <= s_addr0;
    s_q0    <= s_mem0[s_ar0];
    rom_ar0 <= rom_addr0;
    rom_q0  <= rom0[rom_ar0];
    if (d_wren0) d_mem0[d_addr0] <= d_data0;
    if (s_wren1) s_mem1[s_addr1] <= s_data1;
    s_ar1   <= s_addr1;
    s_q1    <= s_mem1[s_ar1];
    rom_ar1 <= rom_addr1;
    rom_q1  <= rom1[rom_ar1];
    if (d_wren1) d_mem1[d_addr1] <= d_data1;
    if (s_wren0 | d_wren0 | s_wren1 | d_wren1) wren_seen <= wren_seen + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit printable(input logic [7:0] c);
    return ((c >= 8'h61) && (c <= 8'h7A)) || (c == 8'h20);
  endfunction

  // Textbook RC4 over ct_m; fills pt_m, returns index of first rejected byte or -1.
  function automatic int model_key(input logic [23:0] key, input int len, input bit chk);
    int s[256];
    int i, j, t;
    logic [7:0] kb[3];
    logic [7:0] p;
    kb[0] = key[23:16];
    kb[1] = key[15:8];
    kb[2] = key[7:0];
    for (int n = 0; n < 256; n++) s[n] = n;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + s[n] + int'(kb[n % 3])) % 256;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    i = 0;
    j = 0;
    for (int k = 0; k < len; k++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      p = 8'(s[(s[i] + s[j]) % 256]) ^ ct_m[k];
      pt_m[k] = p;
      if (chk && !printable(p)) return k;
    end
    return -1;
  endfunction

  // Search outcome and start-to-done cycle count from the per-key cost rules.
  task automatic model_search(input logic [23:0] first, input logic [23:0] last, input int len,
                              input bit chk, output bit f, output logic [23:0] key,
                              output int cyc, output int fail_last);
    int fk;
    cyc = 1;
    f = 1'b0;
    key = last;
    fail_last = -1;
    if (first > last) return;
    for (longint kk = longint'(first); kk <= longint'(last); kk++) begin
      fk = model_key(24'(kk), len, chk);
      if (fk < 0) begin
        f = 1'b1;
        key = 24'(kk);
        cyc += 256 + 2048 + 12 * len;
        fail_last = -1;
        return;
      end
      cyc += 256 + 2048 + 12 * (fk + 1) + 1;
      fail_last = fk;
    end
  endtask

  task automatic run(input bit which, input logic [23:0] first, input logic [23:0] last,
                     input int len, input bit chk, input string tag);
    bit          ef;
    logic [23:0] ek;
    int          ec, efl, cyc, nd;
    logic        d_s, f_s, b_s;
    logic [23:0] k_s;
    logic [7:0]  got;
    for (int n = 0; n < 256; n++) ct_m[n] = which ? rom1[n] : rom0[n];
    model_search(first, last, len, chk, ef, ek, ec, efl);
    sel = which;
    @(negedge clk);
    kf = first;
    kl = last;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    d_s = which ? done1 : done0;
    while (!d_s && cyc < ec + 64) begin
      @(negedge clk);
      cyc++;
      d_s = which ? done1 : done0;
    end
    f_s = which ? found1 : found0;
    k_s = which ? key1 : key0;
    check({tag, ":done"}, 64'(d_s), 64'd1);
    check({tag, ":cycles"}, 64'(cyc), 64'(ec));
    check({tag, ":found"}, 64'(f_s), 64'(ef));
    if (first <= last) begin
      check({tag, ":key"}, 64'(k_s), 64'(ek));
      nd = ef ? len : efl + 1;
      for (int n = 0; n < nd; n++) begin
        got = which ? d_mem1[n] : d_mem0[n];
        check($sformatf("%s:d%0d", tag, n), 64'(got), 64'(pt_m[n]));
      end
    end
    @(negedge clk);
    d_s = which ? done1 : done0;
    f_s = which ? found1 : found0;
    b_s = which ? busy1 : busy0;
    check({tag, ":pulse"}, 64'({d_s, b_s}), 64'd0);
    check({tag, ":held"}, 64'(f_s), 64'(ef));
  endtask

  logic [7:0]  v0[9];
  logic [7:0]  txt[32];
  logic [23:0] r;
  string       pt_str;
  int          snap, c;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    sel = 1'b0;
    start = 1'b0;
    kf = '0;
    kl = '0;
    v0 = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    for (int n = 0; n < 256; n++) begin
      rom0[n] = 8'h00;
      rom1[n] = 8'h00;
    end
    for (int n = 0; n < 9; n++) rom0[n] = v0[n];
    repeat (3) @(negedge clk);
    check("rst0", 64'({busy0, done0, found0, s_wren0, d_wren0, key0, s_addr0, rom_addr0, d_addr0}), 64'd0);
    check("rst1", 64'({busy1, done1, found1, s_wren1, d_wren1, key1, s_addr1, rom_addr1, d_addr1}), 64'd0);
    check("rst_data", 64'({s_data0, d_data0, s_data1, d_data1}), 64'd0);
    rst = 1'b0;

    // Known-answer vector, accept-first mode.
    r = 24'h4B6579 + 24'($urandom_range(0, 1000));
    run(1'b0, 24'h4B6579, r, 9, 1'b0, "kat");
    pt_str = "Plaintext";
    for (int n = 0; n < 9; n++) check($sformatf("kat:txt%0d", n), 64'(d_mem0[n]), 64'(pt_str[n]));

    // Random key and random ciphertext, accept-first mode.
    for (int t = 0; t < 2; t++) begin
      for (int n = 0; n < 9; n++) rom0[n] = 8'($urandom);
      r = 24'($urandom) & 24'h7FFFFF;
      run(1'b0, r, r + 24'($urandom_range(0, 5)), 9, 1'b0, $sformatf("rnd%0d", t));
    end

    // Lowercase/space text encrypted with key 5.
    for (int n = 0; n < 32; n++) begin
      c = $urandom_range(0, 26);
      txt[n] = (c == 26) ? 8'h20 : 8'(8'h61 + c);
      ct_m[n] = 8'h00;
    end
    void'(model_key(24'h000005, 32, 1'b0));
    for (int n = 0; n < 32; n++) rom1[n] = txt[n] ^ pt_m[n];

    run(1'b1, 24'h000000, 24'h00000F, 32, 1'b1, "asc");
    check("asc:key5", 64'(key1), 64'h5);
    for (int n = 0; n < 32; n++) check($sformatf("asc:txt%0d", n), 64'(d_mem1[n]), 64'(txt[n]));

    run(1'b1, 24'h000006, 24'h00000F, 32, 1'b1, "miss");
    check("miss:keyF", 64'({found1, key1}), 64'h00000F);

    snap = wren_seen;
    run(1'b1, 24'h000010, 24'h00000F, 32, 1'b1, "empty");
    check("empty:wren", 64'(wren_seen - snap), 64'd0);

    run(1'b1, 24'hFFFFFF, 24'hFFFFFF, 32, 1'b1, "top");

    // Reset in the middle of the key schedule, then a fresh search.
    sel = 1'b1;
    @(negedge clk);
    kf = 24'h000003;
    kl = 24'h00000F;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (1000) @(negedge clk);
    check("mid:busy", 64'({busy1, key1}), 64'h1000003);
    rst = 1'b1;
    #1;
    check("mid:rst", 64'({busy1, done1, found1, s_wren1, d_wren1, key1, s_addr1, rom_addr1, d_addr1}), 64'd0);
    check("mid:rst_data", 64'({s_data1, d_data1}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run(1'b1, 24'h000003, 24'h00000F, 32, 1'b1, "rerun");
    check("rerun:key5", 64'(key1), 64'h5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
